if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and drives a req/ack instruction bus. Holds one fetched instruction in a single-entry buffer and presents it as if_pc/if_inst.
- Handles redirects from flush (exception/new_pc) and branches (delay-slot semantics).
- Requests a pipeline stall while no instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
ADDR_W, 32, instruction address width (matches `InstAddrBus)
DATA_W, 32, instruction width (matches `InstBus)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
stall  in  6  pipeline stall vector from ctrl; bit0 = IF stage
flush  in  1  pipeline flush; redirect to new_pc
new_pc  in  ADDR_W  flush target (exception vector / eret address)
branch_flag_i  in  1  ID resolved a taken branch/jump
branch_target_address_i  in  ADDR_W  branch target
ibus_req  out  1  instruction bus request
ibus_addr  out  ADDR_W  request address, word aligned
ibus_rdata  in  DATA_W  read data, valid when ibus_ack=1
ibus_ack  in  1  request completed this cycle (same-cycle ack allowed)
if_pc  out  ADDR_W  PC of buffered instruction, else 0
if_inst  out  DATA_W  buffered instruction, else 0
stallreq_from_if  out  1  no instruction available

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, buf_valid=0, state=IDLE, ibus_req=0. if_pc/if_inst read 0. stallreq_from_if=1.
- Reset mid-transaction abandons it. The bus is expected to be reset with the core.
- consume = buf_valid && stall[0]==`NoStop. At that edge the IF/ID register accepts the buffered instruction.
- Outputs are combinational from the buffer:
  - if_pc = buf_valid ? buf_pc : 0
  - if_inst = buf_valid ? buf_inst : 0
  - stallreq_from_if = !buf_valid
- States: IDLE, RUN, DISCARD.
- IDLE: one cycle after reset release, ibus_req=0. Next state RUN.
- RUN:
  - ibus_req = !buf_valid || consume; ibus_addr = fetch_pc.
  - Once asserted, req and addr stay stable until ack.
  - On ack without redirect: buf <= {fetch_pc, ibus_rdata}, buf_valid<=1, fetch_pc<=fetch_pc+4 (mod 2^ADDR_W, wraps silently).
  - On consume without ack: buf_valid<=0.
  - Zero-wait bus sustains 1 instruction/cycle.
- Flush (highest priority, any state):
  - fetch_pc<=new_pc, buf_valid<=0.
  - A same-cycle ack is dropped.
  - If ibus_req=1 and no ack this cycle: state<=DISCARD, else RUN.
- Branch: sampled only on a consume edge with flush=0.
  - The consumed buffered instruction is the delay slot and passes normally.
  - fetch_pc<=branch_target_address_i; a same-cycle ack is dropped (buf_valid<=0).
  - An outstanding unacked request goes to DISCARD.
  - Ctrl holds branch_flag_i until a consume edge occurs.
- DISCARD:
  - ibus_req=1 with the stale address until ack; the data is dropped; buf_valid stays 0.
  - Then state goes to RUN and fetches the redirected fetch_pc.
  - A flush during DISCARD updates fetch_pc and remains in DISCARD.
- stall[0]=`Stop with buf_valid=1: buffer held, no new request, fetch_pc unchanged.
- Misaligned target: ibus_addr[1:0] forced to 0. Alignment exceptions are raised downstream.

Decomposition:
- Use `RstEnable, `Stop/`NoStop, `ZeroWord, `InstBus and `InstAddrBus from Defines.vh.
- Add to Defines.vh: fetch state encodings (`IfIdle, `IfRun, `IfDiscard) and `PcInc (32'd4).
- No sub-module; the buffer and FSM stay in one module.

Test Plan:
- Reset release, zero-wait ack, stall=0 -> ibus_addr 0x0,0x4,0x8 on consecutive RUN cycles; if_pc follows one cycle later; stallreq_from_if=0 from the 3rd cycle.
- Ack delayed 3 cycles -> ibus_req/ibus_addr stable across all 3; stallreq_from_if=1; if_inst=0 until the ack edge, then the captured word.
- stall[0]=1 for 4 cycles with buf_valid=1 -> if_pc/if_inst unchanged, ibus_req=0; resumes at +4 on release.
- Branch on consume with buffered PC 0x100 and target 0x200 -> 0x100 delivered (delay slot), next fetched address 0x200; the word at 0x104, if acked that cycle, is dropped.
- Flush (new_pc=0x180) while a request to 0x40 is pending unacked -> DISCARD; 0x40 data dropped on ack; next request 0x180; if_inst=0 throughout.
- Reset asserted mid-request -> outputs 0 and ibus_req=0 immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_pkg
// Purpose  : Shared constants and the fetch-state encoding used by the
//            instruction-fetch stage.
// Contents : RST_ENABLE / STOP / NO_STOP  - control polarity constants
//            PC_INC                      - sequential fetch increment (bytes)
//            if_state_e                  - IF_IDLE / IF_RUN / IF_DISCARD
// Revision : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam int   PC_INC     = 4;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_RUN     = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

endpackage : if_fetch_pkg
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction-fetch stage feeding the IF/ID register. Owns the
//            fetch PC, runs a req/ack instruction bus, keeps one fetched
//            instruction in a single-entry buffer and handles flush and
//            delay-slot branch redirects.
// Ports    : clk, rst                    - clock / async active-high reset
//            stall[5:0]                  - pipeline stall vector, bit0 = IF
//            flush, new_pc               - flush redirect
//            branch_flag_i,
//            branch_target_address_i     - branch redirect from ID
//            ibus_req, ibus_addr         - instruction bus request
//            ibus_rdata, ibus_ack        - instruction bus response
//            if_pc, if_inst              - buffered instruction (0 if empty)
//            stallreq_from_if            - no instruction available
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  output logic              ibus_req,
  output logic [ADDR_W-1:0] ibus_addr,
  input  logic [DATA_W-1:0] ibus_rdata,
  input  logic              ibus_ack,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              stallreq_from_if
);

  if_state_e         state_q,      state_d;
  logic [ADDR_W-1:0] fetch_pc_q,   fetch_pc_d;
  logic [ADDR_W-1:0] stale_addr_q, stale_addr_d;
  logic [ADDR_W-1:0] buf_pc_q,     buf_pc_d;
  logic [DATA_W-1:0] buf_inst_q,   buf_inst_d;
  logic              buf_valid_q,  buf_valid_d;

  logic              consume;
  logic              ack_taken;
  logic [ADDR_W-1:0] fetch_addr;
  logic              unused_stall;

  // Only the IF bit of the stall vector concerns this stage.
  assign unused_stall = ^stall[5:1];

  // IF/ID takes the buffered instruction at the edge ending this cycle.
  assign consume    = buf_valid_q && (stall[0] == NO_STOP);
  assign ack_taken  = ibus_req && ibus_ack;
  assign fetch_addr = {fetch_pc_q[ADDR_W-1:2], 2'b00};

  // --------------------------------------------------------------------------
  // Bus request. In RUN a request is raised when the buffer is empty or is
  // being drained this cycle; once raised, buf_valid stays 0 (or the consume
  // edge clears it) so req and addr hold until the ack arrives.
  // DISCARD keeps presenting the address of the abandoned request, which may
  // differ from the already-redirected fetch_pc.
  // --------------------------------------------------------------------------
  always_comb begin
    ibus_req  = 1'b0;
    ibus_addr = fetch_addr;
    case (state_q)
      IF_RUN:     ibus_req = !buf_valid_q || consume;
      IF_DISCARD: begin
        ibus_req  = 1'b1;
        ibus_addr = stale_addr_q;
      end
      default:    ibus_req = 1'b0;
    endcase
  end

  assign if_pc            = buf_valid_q ? buf_pc_q   : '0;
  assign if_inst          = buf_valid_q ? buf_inst_q : '0;
  assign stallreq_from_if = !buf_valid_q;

  // --------------------------------------------------------------------------
  // Next-state logic. Flush is evaluated last so it overrides everything.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    stale_addr_d = stale_addr_q;
    buf_pc_d     = buf_pc_q;
    buf_inst_d   = buf_inst_q;
    buf_valid_d  = buf_valid_q;

    case (state_q)
      IF_IDLE: state_d = IF_RUN;

      IF_RUN: begin
        if (ack_taken) begin
          buf_pc_d    = fetch_pc_q;
          buf_inst_d  = ibus_rdata;
          buf_valid_d = 1'b1;
          fetch_pc_d  = fetch_pc_q + ADDR_W'(PC_INC);
        end else if (consume) begin
          buf_valid_d = 1'b0;
        end

        // The instruction consumed now is the delay slot and leaves
        // normally; whatever the bus is fetching behind it is wrong-path.
        if (consume && branch_flag_i) begin
          fetch_pc_d  = branch_target_address_i;
          buf_valid_d = 1'b0;
          if (!ibus_ack) begin
            state_d      = IF_DISCARD;
            stale_addr_d = ibus_addr;
          end
        end
      end

      IF_DISCARD: begin
        // Stale data is swallowed; the buffer was already emptied on entry.
        if (ibus_ack) begin
          state_d = IF_RUN;
        end
      end

      default: state_d = IF_IDLE;
    endcase

    if (flush) begin
      fetch_pc_d  = new_pc;
      buf_valid_d = 1'b0;
      if (ibus_req && !ibus_ack) begin
        state_d      = IF_DISCARD;
        stale_addr_d = ibus_addr;
      end else begin
        state_d = IF_RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q      <= IF_IDLE;
      fetch_pc_q   <= RESET_PC;
      stale_addr_q <= '0;
      buf_pc_q     <= '0;
      buf_inst_q   <= '0;
      buf_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      stale_addr_q <= stale_addr_d;
      buf_pc_q     <= buf_pc_d;
      buf_inst_q   <= buf_inst_d;
      buf_valid_q  <= buf_valid_d;
    end
  end

endmodule : if_fetch
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Purpose  : Self-checking bench for if_fetch. A bus responder with a
//            programmable ack latency returns a pure function of the word
//            address; a program-order model predicts the PC of every
//            instruction handed to IF/ID (sequential, flush target, or
//            branch target after the delay slot).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic [31:0] ibus_rdata;
  logic        ibus_ack;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_from_if;

  if_fetch #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .ibus_req                (ibus_req),
    .ibus_addr               (ibus_addr),
    .ibus_rdata              (ibus_rdata),
    .ibus_ack                (ibus_ack),
    .if_pc                   (if_pc),
    .if_inst                 (if_inst),
    .stallreq_from_if        (stallreq_from_if)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;
  int          wait_cnt;
  int          ack_lat;
  logic        prev_pending;
  logic [31:0] prev_addr;
  int          since_deliver;
  int          n_disc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return {w[15:0], ~w[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle. Inputs are set by the caller just after the previous
  // edge; this task answers the bus, updates the program-order model and
  // returns 1 time unit after the next rising edge.
  task automatic tick();
    logic        pre_consume;
    logic [31:0] pre_pc;
    logic [31:0] pre_inst;
    #1;
    if (prev_pending) begin
      chk("req_hold", ibus_req, 1);
      chk("addr_hold", ibus_addr, prev_addr);
    end
    if (ibus_req) chk("addr_align", ibus_addr[1:0], 0);
    ibus_ack   = ibus_req && (wait_cnt >= ack_lat);
    ibus_rdata = ibus_ack ? mem_word(ibus_addr) : 32'hDEAD_BEEF;
    #1;
    pre_consume = !stallreq_from_if && !stall[0];
    pre_pc      = if_pc;
    pre_inst    = if_inst;
    since_deliver++;
    if (flush) begin
      exp_pc = new_pc;
    end else if (pre_consume) begin
      chk("deliver_pc", pre_pc, exp_pc);
      chk("deliver_inst", pre_inst, mem_word(exp_pc));
      exp_pc        = branch_flag_i ? branch_target_address_i : exp_pc + 32'd4;
      since_deliver = 0;
    end
    prev_pending = ibus_req && !ibus_ack;
    prev_addr    = ibus_addr;
    wait_cnt     = prev_pending ? wait_cnt + 1 : 0;
    @(posedge clk);
    #1;
    ibus_ack = 1'b0;
    if (stallreq_from_if) begin
      chk("empty_pc", if_pc, 0);
      chk("empty_inst", if_inst, 0);
    end else begin
      chk("buf_inst", if_inst, mem_word(if_pc));
    end
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
    branch_flag_i = 1'b0; branch_target_address_i = '0;
    ibus_ack = 1'b0; ibus_rdata = '0;
    ack_lat = 0; wait_cnt = 0; prev_pending = 1'b0; prev_addr = '0;
    exp_pc = RESET_PC; since_deliver = 0; n_disc = 0;

    // Reset state
    #2;
    chk("rst_req", ibus_req, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_inst", if_inst, 0);
    chk("rst_stallreq", stallreq_from_if, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero-wait streaming
    chk("idle_req", ibus_req, 0);
    chk("idle_stallreq", stallreq_from_if, 1);
    tick();
    chk("run0_req", ibus_req, 1);
    chk("run0_addr", ibus_addr, 32'h0);
    chk("run0_stallreq", stallreq_from_if, 1);
    tick();
    chk("run1_addr", ibus_addr, 32'h4);
    chk("run1_pc", if_pc, 32'h0);
    chk("run1_stallreq", stallreq_from_if, 0);
    tick();
    chk("run2_addr", ibus_addr, 32'h8);
    chk("run2_pc", if_pc, 32'h4);

    // Ack delayed by 3 cycles
    ack_lat = 3;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("slow_req", ibus_req, 1);
      chk("slow_addr", ibus_addr, 32'h8);
      chk("slow_stallreq", stallreq_from_if, 1);
      chk("slow_inst", if_inst, 0);
      tick();
    end
    chk("slow_pc", if_pc, 32'h8);
    chk("slow_inst_cap", if_inst, mem_word(32'h8));
    ack_lat = 0;

    // IF stall with a full buffer (upper stall bits are irrelevant)
    stall = 6'b110001;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_req", ibus_req, 0);
      chk("stall_pc", if_pc, 32'h8);
      chk("stall_inst", if_inst, mem_word(32'h8));
      tick();
    end
    stall = 6'b111110;
    #1;
    chk("resume_req", ibus_req, 1);
    chk("resume_addr", ibus_addr, 32'hC);
    tick();
    chk("resume_pc", if_pc, 32'hC);

    // Branch: delay slot at 0x100, target 0x200, word at 0x104 dropped
    stall = 6'b000001; flush = 1'b1; new_pc = 32'h100;
    tick();
    flush = 1'b0;
    tick();
    chk("br_slot_pc", if_pc, 32'h100);
    chk("br_stalled_req", ibus_req, 0);
    stall = 6'b000000; branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
    #1;
    chk("br_wrong_addr", ibus_addr, 32'h104);
    tick();
    branch_flag_i = 1'b0;
    chk("br_drop_stallreq", stallreq_from_if, 1);
    chk("br_drop_inst", if_inst, 0);
    chk("br_tgt_req", ibus_req, 1);
    chk("br_tgt_addr", ibus_addr, 32'h200);
    tick();
    chk("br_tgt_pc", if_pc, 32'h200);

    // Flush while a request to 0x40 is outstanding
    stall = 6'b000001; flush = 1'b1; new_pc = 32'h40;
    tick();
    flush = 1'b0;
    ack_lat = 2;
    tick();
    chk("pend_req", ibus_req, 1);
    chk("pend_addr", ibus_addr, 32'h40);
    flush = 1'b1; new_pc = 32'h180;
    tick();
    flush = 1'b0;
    n_disc = 0;
    while (ibus_addr == 32'h40 && n_disc < 10) begin
      chk("disc_inst", if_inst, 0);
      chk("disc_req", ibus_req, 1);
      tick();
      n_disc++;
    end
    chk("disc_cycles", n_disc, 1);
    chk("redir_req", ibus_req, 1);
    chk("redir_addr", ibus_addr, 32'h180);
    chk("redir_inst", if_inst, 0);
    ack_lat = 0;
    tick();
    chk("redir_pc", if_pc, 32'h180);

    // Misaligned redirect target
    flush = 1'b1; new_pc = 32'h203;
    tick();
    flush = 1'b0;
    chk("mis_addr", ibus_addr, 32'h200);
    tick();
    chk("mis_pc", if_pc, 32'h203);
    stall = 6'b000000;
    tick();
    chk("mis_next_pc", if_pc, 32'h207);

    // Reset asserted mid-request
    ack_lat = 5;
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_req", ibus_req, 0);
    chk("mrst_pc", if_pc, 0);
    chk("mrst_inst", if_inst, 0);
    chk("mrst_stallreq", stallreq_from_if, 1);
    prev_pending = 1'b0; wait_cnt = 0; exp_pc = RESET_PC; ack_lat = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_idle_req", ibus_req, 0);
    tick();
    chk("mrst_restart_addr", ibus_addr, RESET_PC);
    tick();
    chk("mrst_restart_pc", if_pc, RESET_PC);

    // Randomized traffic against the program-order model
    since_deliver = 0;
    for (int c = 0; c < 3000; c++) begin
      stall[5:1] = 5'($urandom);
      stall[0]   = ($urandom_range(0, 99) < 30);
      flush      = ($urandom_range(0, 99) < 3);
      new_pc     = 32'($urandom_range(0, 4095)) << 2;
      if ($urandom_range(0, 9) == 0) new_pc[1:0] = 2'($urandom);
      branch_flag_i           = ($urandom_range(0, 99) < 10);
      branch_target_address_i = 32'($urandom_range(0, 4095)) << 2;
      if (wait_cnt == 0) ack_lat = $urandom_range(0, 3);
      tick();
      if (since_deliver > 60) begin
        chk("progress", since_deliver, 0);
        since_deliver = 0;
      end
    end
    flush = 1'b0; branch_flag_i = 1'b0; stall = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_if_fetch
`default_nettype wire
